// File: rtl/iobs_pkg.sv
// Shared types for the I/O bridge slave: transfer-sequencer states and the
// posted-write FIFO entry layout at the default bus widths.
package iobs_pkg;

    localparam int IOBS_AW = 23;
    localparam int IOBS_DW = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAITACT  = 2'd2,
        WAITDONE = 2'd3
    } ts_e;

    typedef struct packed {
        logic [IOBS_AW-1:0] addr;
        logic [IOBS_DW-1:0] data;
        logic               l;
        logic               u;
    } iobs_entry_t;

endpackage

// File: rtl/iobs_pwfifo.sv
// Circular posted-write buffer: read/write pointers plus an occupancy count,
// head entry presented combinationally from the read pointer.
module iobs_pwfifo
    import iobs_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  LW      = $clog2(DEPTH + 1),
    parameter type entry_t = iobs_entry_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;

    assign head_o  = mem_q[rptr_q];
    assign level_o = cnt_q;
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; only pointers and count are, which makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_i && full_o));
            assert (!(pop_i && empty_o));
        end
    end

endmodule

// File: rtl/iobs_fifo.sv
// FSB-to-IOBM bridge slave: posted writes go through the FIFO, non-posted
// accesses bypass it once the FIFO has drained, errors are reported per path.
module iobs_fifo
    import iobs_pkg::*;
#(
    parameter int AW    = IOBS_AW,
    parameter int DW    = IOBS_DW,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRES,
    input  logic          nAS,
    input  logic          nWE,
    input  logic          nLDS,
    input  logic          nUDS,
    input  logic          BACT,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic          IOCS,
    input  logic          IORealCS,
    input  logic          IOPWCS,
    output logic          IONPReady,
    output logic          IOPWReady,
    output logic          nBERR_FSB,
    output logic          nDinOE,
    output logic          IORDREQ,
    output logic          IOWRREQ,
    output logic [AW-1:0] IOA,
    output logic [DW-1:0] IOD,
    output logic          IOL,
    output logic          IOU,
    input  logic          IOACT,
    input  logic          IODONEin,
    input  logic          IOBERR,
    output logic [LW-1:0] LEVEL,
    output logic          PWERR,
    input  logic          PWERRclr
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          l;
        logic          u;
    } entry_t;

    ts_e           ts_q, ts_d;
    logic          ioact_q, iodone_q;
    logic          sent_q, sent_d;
    logic          rdreq_q, rdreq_d;
    logic          wrreq_q, wrreq_d;
    logic [AW-1:0] ioa_q, ioa_d;
    logic [DW-1:0] iod_q, iod_d;
    logic          iol_q, iol_d;
    logic          iou_q, iou_d;
    logic          src_fifo_q, src_fifo_d;
    logic          npready_q, npready_d;
    logic          nberr_q, nberr_d;
    logic          pwerr_q, pwerr_d;

    logic          posted_cyc, push, pop, np_pending, np_start;
    logic          full, empty;
    entry_t        push_entry, head;

    // A write into a posted-write region never waits for IOBM completion.
    assign posted_cyc = IOPWCS && !nWE;
    assign push       = BACT && IOCS && posted_cyc && !sent_q && !full;
    assign np_pending = BACT && IOCS && !posted_cyc && !sent_q;
    assign push_entry = '{addr: A, data: D, l: !nLDS, u: !nUDS};

    iobs_pwfifo #(
        .DEPTH   (DEPTH),
        .LW      (LW),
        .entry_t (entry_t)
    ) u_pwfifo (
        .clk_i       (CLK),
        .rst_ni      (nRES),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .level_o     (LEVEL),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        ts_d       = ts_q;
        rdreq_d    = rdreq_q;
        wrreq_d    = wrreq_q;
        ioa_d      = ioa_q;
        iod_d      = iod_q;
        iol_d      = iol_q;
        iou_d      = iou_q;
        src_fifo_d = src_fifo_q;
        pop        = 1'b0;
        np_start   = 1'b0;
        case (ts_q)
            IDLE: begin
                // Draining the FIFO first is what keeps reads behind earlier posted writes.
                if (!empty) begin
                    pop        = 1'b1;
                    ioa_d      = head.addr;
                    iod_d      = head.data;
                    iol_d      = head.l;
                    iou_d      = head.u;
                    rdreq_d    = 1'b0;
                    wrreq_d    = 1'b1;
                    src_fifo_d = 1'b1;
                    ts_d       = START;
                end else if (np_pending) begin
                    np_start   = 1'b1;
                    ioa_d      = A;
                    iod_d      = D;
                    iol_d      = !nLDS;
                    iou_d      = !nUDS;
                    rdreq_d    = nWE;
                    wrreq_d    = !nWE;
                    src_fifo_d = 1'b0;
                    ts_d       = START;
                end
            end
            START:    ts_d = WAITACT;
            WAITACT: begin
                if (ioact_q) begin
                    rdreq_d = 1'b0;
                    wrreq_d = 1'b0;
                    ts_d    = WAITDONE;
                end
            end
            WAITDONE: if (!ioact_q) ts_d = IDLE;
            default:  ts_d = IDLE;
        endcase
    end

    always_comb begin
        sent_d    = sent_q;
        npready_d = npready_q;
        nberr_d   = nberr_q;
        pwerr_d   = pwerr_q;
        if (!BACT) begin
            sent_d    = 1'b0;
            npready_d = 1'b0;
            nberr_d   = 1'b1;
        end else begin
            if (push || np_start)                         sent_d    = 1'b1;
            if (sent_q && !posted_cyc && iodone_q)        npready_d = 1'b1;
            if (sent_q && !posted_cyc && IOBERR)          nberr_d   = 1'b0;
        end
        // Set beats clear so an error arriving with the clear is not lost.
        if ((ts_q != IDLE) && src_fifo_q && IOBERR) pwerr_d = 1'b1;
        else if (PWERRclr)                          pwerr_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            ts_q       <= IDLE;
            ioact_q    <= 1'b0;
            iodone_q   <= 1'b0;
            sent_q     <= 1'b0;
            rdreq_q    <= 1'b0;
            wrreq_q    <= 1'b0;
            ioa_q      <= '0;
            iod_q      <= '0;
            iol_q      <= 1'b0;
            iou_q      <= 1'b0;
            src_fifo_q <= 1'b0;
            npready_q  <= 1'b0;
            nberr_q    <= 1'b1;
            pwerr_q    <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            ioact_q    <= IOACT;
            iodone_q   <= IODONEin;
            sent_q     <= sent_d;
            rdreq_q    <= rdreq_d;
            wrreq_q    <= wrreq_d;
            ioa_q      <= ioa_d;
            iod_q      <= iod_d;
            iol_q      <= iol_d;
            iou_q      <= iou_d;
            src_fifo_q <= src_fifo_d;
            npready_q  <= npready_d;
            nberr_q    <= nberr_d;
            pwerr_q    <= pwerr_d;
        end
    end

    assign IOPWReady = sent_q || !full;
    assign nDinOE    = !(!nAS && BACT && IORealCS && nWE);
    assign IORDREQ   = rdreq_q;
    assign IOWRREQ   = wrreq_q;
    assign IOA       = ioa_q;
    assign IOD       = iod_q;
    assign IOL       = iol_q;
    assign IOU       = iou_q;
    assign IONPReady = npready_q;
    assign nBERR_FSB = nberr_q;
    assign PWERR     = pwerr_q;

endmodule

// File: tb/tb_iobs_fifo.sv
// Directed bench for iobs_fifo: posted-write backpressure and ordering,
// read-after-write, non-posted handshake, error paths and mid-transfer reset.
module tb_iobs_fifo;
    import iobs_pkg::*;

    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          nRES = 1'b0;
    logic          nAS = 1'b1, nWE = 1'b1, nLDS = 1'b1, nUDS = 1'b1, BACT = 1'b0;
    logic [AW-1:0] A = '0;
    logic [DW-1:0] D = '0;
    logic          IOCS = 1'b0, IORealCS = 1'b0, IOPWCS = 1'b0;
    logic          IONPReady, IOPWReady, nBERR_FSB, nDinOE, IORDREQ, IOWRREQ;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic          IOL, IOU;
    logic          IOACT = 1'b0, IODONEin = 1'b0, IOBERR = 1'b0;
    logic [LW-1:0] LEVEL;
    logic          PWERR;
    logic          PWERRclr = 1'b0;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [AW-1:0] a_seen;
    logic          we_seen;

    iobs_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .CLK(CLK), .nRES(nRES), .nAS(nAS), .nWE(nWE), .nLDS(nLDS), .nUDS(nUDS),
        .BACT(BACT), .A(A), .D(D), .IOCS(IOCS), .IORealCS(IORealCS), .IOPWCS(IOPWCS),
        .IONPReady(IONPReady), .IOPWReady(IOPWReady), .nBERR_FSB(nBERR_FSB),
        .nDinOE(nDinOE), .IORDREQ(IORDREQ), .IOWRREQ(IOWRREQ), .IOA(IOA), .IOD(IOD),
        .IOL(IOL), .IOU(IOU), .IOACT(IOACT), .IODONEin(IODONEin), .IOBERR(IOBERR),
        .LEVEL(LEVEL), .PWERR(PWERR), .PWERRclr(PWERRclr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        BACT = 1'b0; nAS = 1'b1; nWE = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
        IOCS = 1'b0; IORealCS = 1'b0; IOPWCS = 1'b0;
    endtask

    task automatic fsb_start(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic we_n, input logic pw, input logic lds_n, input logic uds_n);
        BACT = 1'b1; nAS = 1'b0; nWE = we_n; nLDS = lds_n; nUDS = uds_n;
        IOCS = 1'b1; IORealCS = 1'b1; IOPWCS = pw; A = addr; D = data;
    endtask

    // One posted write: BACT for one edge (push), then one idle edge.
    task automatic pw(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic lds_n, input logic uds_n);
        fsb_start(addr, data, 1'b0, 1'b1, lds_n, uds_n);
        #1;
        check("pw_ready", IOPWReady, 1);
        check("pw_dinoe", nDinOE, 1);
        tick();
        bus_idle();
        tick();
    endtask

    // Plays the IOBM side of one transfer: IOACT raised right after the request
    // is seen, dropped after two edges together with optional DONE/BERR pulses.
    task automatic serve(input logic done, input logic berr, input logic clr,
                         output logic [AW-1:0] addr, output logic we);
        int t = 0;
        while (!(IORDREQ || IOWRREQ) && t < 40) begin
            tick();
            t++;
        end
        check("req_seen", IORDREQ | IOWRREQ, 1);
        addr  = IOA;
        we    = IOWRREQ;
        IOACT = 1'b1;
        tick();
        tick();
        check("req_drop", {IORDREQ, IOWRREQ}, 0);
        IOACT = 1'b0; IODONEin = done; IOBERR = berr; PWERRclr = clr;
        tick();
        IODONEin = 1'b0; IOBERR = 1'b0; PWERRclr = 1'b0;
        if (done) check("np_early", IONPReady, 0);
        tick();
    endtask

    initial begin
        // Reset state.
        bus_idle();
        tick();
        tick();
        check("rst_level", LEVEL, 0);
        check("rst_wrreq", IOWRREQ, 0);
        check("rst_rdreq", IORDREQ, 0);
        check("rst_npready", IONPReady, 0);
        check("rst_nberr", nBERR_FSB, 1);
        check("rst_pwerr", PWERR, 0);
        check("rst_ioa", IOA, 0);
        check("rst_iod", IOD, 0);
        check("rst_ts", 32'(dut.ts_q), 32'(IDLE));
        check("rst_pwready", IOPWReady, 1);
        check("rst_dinoe", nDinOE, 1);
        nRES = 1'b1;
        tick();

        // Backpressure: entry 0x100 is popped at once and stalls in WAITACT,
        // so writes 2..5 fill the four entries and the sixth must wait.
        for (int i = 1; i <= 5; i++) pw(AW'(i * 'h100), DW'(i * 'h1111), 1'b0, 1'b0);
        check("s1_level_full", LEVEL, 4);
        check("s1_stall_req", IOWRREQ, 1);
        fsb_start(23'h000600, 16'h6666, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("s1_pwready_full", IOPWReady, 0);
        tick();
        check("s1_not_pushed", LEVEL, 4);
        check("s1_pwready_held", IOPWReady, 0);
        serve(1'b0, 1'b0, 1'b0, a_seen, we_seen);
        check("s1_order_0", a_seen, 32'h100);
        check("s1_still_full", IOPWReady, 0);
        tick();
        check("s1_after_pop", LEVEL, 3);
        check("s1_pwready_back", IOPWReady, 1);
        tick();
        check("s1_sixth_pushed", LEVEL, 4);
        check("s1_pwready_sent", IOPWReady, 1);
        bus_idle();
        tick();
        for (int i = 2; i <= 6; i++) begin
            serve(1'b0, 1'b0, 1'b0, a_seen, we_seen);
            check("s1_order", a_seen, 32'(i * 'h100));
            check("s1_is_write", we_seen, 1);
        end
        check("s1_last_data", IOD, 32'h6666);
        check("s1_drained", LEVEL, 0);

        // Read-after-write: the read request only follows the 0x0F00 write.
        pw(23'h000F00, 16'hBEEF, 1'b0, 1'b1);
        fsb_start(23'h000ABC, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("s2_dinoe_read", nDinOE, 0);
        check("s2_no_rdreq", IORDREQ, 0);
        serve(1'b0, 1'b0, 1'b0, a_seen, we_seen);
        check("s2_first_addr", a_seen, 32'h0F00);
        check("s2_first_we", we_seen, 1);
        check("s2_first_data", IOD, 32'hBEEF);
        check("s2_first_lu", {IOL, IOU}, 32'b10);
        serve(1'b1, 1'b0, 1'b0, a_seen, we_seen);
        check("s2_read_addr", a_seen, 32'h0ABC);
        check("s2_read_we", we_seen, 0);
        check("s2_npready", IONPReady, 1);
        check("s2_read_lu", {IOL, IOU}, 32'b11);
        bus_idle();
        tick();
        check("s2_npready_clr", IONPReady, 0);

        // Non-posted write with bus error.
        fsb_start(23'h000123, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b0, a_seen, we_seen);
        check("s3_addr", a_seen, 32'h0123);
        check("s3_we", we_seen, 1);
        check("s3_data", IOD, 32'h5A5A);
        check("s3_nberr", nBERR_FSB, 0);
        check("s3_npready", IONPReady, 0);
        check("s3_pwerr", PWERR, 0);
        bus_idle();
        tick();
        check("s3_nberr_rel", nBERR_FSB, 1);

        // Posted write with bus error: sticky flag, clear, set-beats-clear.
        pw(23'h000222, 16'h2222, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b0, a_seen, we_seen);
        check("s4_addr", a_seen, 32'h0222);
        check("s4_pwerr", PWERR, 1);
        check("s4_nberr", nBERR_FSB, 1);
        PWERRclr = 1'b1;
        tick();
        PWERRclr = 1'b0;
        check("s4_pwerr_clr", PWERR, 0);
        pw(23'h000333, 16'h3333, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b1, a_seen, we_seen);
        check("s4_set_wins", PWERR, 1);
        PWERRclr = 1'b1;
        tick();
        PWERRclr = 1'b0;
        check("s4_pwerr_clr2", PWERR, 0);

        // Reset in WAITACT with three entries queued.
        for (int i = 1; i <= 4; i++) pw(AW'(i * 'h10), DW'(i), 1'b0, 1'b0);
        check("s5_ts_pre", 32'(dut.ts_q), 32'(WAITACT));
        check("s5_level_pre", LEVEL, 3);
        check("s5_req_pre", IOWRREQ, 1);
        nRES = 1'b0;
        tick();
        check("s5_req_post", IOWRREQ, 0);
        check("s5_level_post", LEVEL, 0);
        check("s5_ts_post", 32'(dut.ts_q), 32'(IDLE));
        check("s5_ioa_post", IOA, 0);
        nRES = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
